// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a single FIFO write port.
// Grants one lane at a time for bursts of up to MAX_BURST words.
module fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic [NREQ-1:0]    last,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic             fifo_we,
    output logic [DW-1:0]    fifo_din,
    input  logic             fifo_full,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [3:0]      burst_cnt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [PW-1:0]   g_idx;
    logic [3:0]      cnt_nxt;
    logic            ack_g;
    logic            last_g;
    logic            req_g;
    logic            release_g;

    // First requesting lane at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        pick_idx   = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    // Lane index of the held grant, and its data mux
    always_comb begin
        g_idx    = '0;
        fifo_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_idx    = PW'(i);
                fifo_din = din[i*DW +: DW];
            end
        end
    end

    // Write acknowledge; gnt is zero outside BURST so no state gating needed
    always_comb begin
        ack       = gnt & req & {NREQ{!fifo_full}};
        fifo_we   = |ack;
        ack_g     = |ack;
        last_g    = |(ack & last);
        req_g     = |(gnt & req);
        cnt_nxt   = burst_cnt + 4'd1;
        release_g = last_g
                  || (ack_g && cnt_nxt == 4'(MAX_BURST))
                  || !req_g;
    end

    // Arbitration FSM with registered grant and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt       <= {{(NREQ-1){1'b0}}, 1'b1}
                                     << pick_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (ack_g) begin
                        burst_cnt <= cnt_nxt;
                    end
                    if (release_g) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        rr_ptr <= (g_idx == PW'(NREQ-1))
                                  ? '0 : g_idx + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: fixed vector table, directed corner
// sequences and random traffic against a lane-level model.
module tb_fifo_wr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        fifo_we;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        busy;

    int nvec = 0;
    int nbad = 0;

    // Model: granted lane (-1 none), words this grant, next priority
    int mg;
    int mcnt;
    int mptr;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] l;
        logic       f;
        logic [3:0] eg;
        logic [3:0] ea;
        logic       ew;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [22];

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NREQ(NREQ),
        .DW(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .din(din),
        .last(last),
        .gnt(gnt),
        .ack(ack),
        .fifo_we(fifo_we),
        .fifo_din(fifo_din),
        .fifo_full(fifo_full),
        .busy(busy)
    );

    function automatic logic [31:0] dut_out();
        return {14'd0, gnt, ack, fifo_we, fifo_din, busy};
    endfunction

    function automatic logic [31:0] model_out();
        logic [3:0] g;
        logic [3:0] a;
        logic [7:0] d;
        int         l;
        l = (mg < 0) ? 0 : mg;
        g = (mg < 0) ? 4'd0 : 4'(1 << l);
        a = (mg >= 0 && req[l] && !fifo_full) ? g : 4'd0;
        d = (mg < 0) ? 8'd0 : din[l*8 +: 8];
        return {14'd0, g, a, |a, d, mg >= 0};
    endfunction

    task automatic model_step();
        bit a;
        bit found;
        int idx;
        if (mg < 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (!found && req[idx]) begin
                    found = 1;
                    mg    = idx;
                    mcnt  = 0;
                end
            end
        end else begin
            a = req[mg] && !fifo_full;
            if (a) mcnt++;
            if ((a && last[mg]) || (a && mcnt == MB) || !req[mg]) begin
                mptr = (mg + 1) % NREQ;
                mg   = -1;
            end
        end
    endtask

    task automatic check(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic [3:0] l,
                         input logic f, output logic we_o,
                         output logic [31:0] o);
        req       = r;
        last      = l;
        fifo_full = f;
        @(negedge clk);
        o    = dut_out();
        we_o = fifo_we;
        check("model", o, model_out());
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        mg        = -1;
        mcnt      = 0;
        mptr      = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", dut_out(), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        we;
        logic [31:0] o;
        int          fcnt;

        din = 32'h44332211;

        tbl = '{
            '{4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33},
            '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33},
            '{4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h33},
            '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22},
            '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h22},
            '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h22},
            '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h44},
            '{4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h44},
            '{4'b0001, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'h44},
            '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00},
            '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h11},
            '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h11}
        };

        // Fixed vectors: lane 2 packet, lane 1 stalled, lane 3 drop
        do_reset();
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].r, tbl[i].l, tbl[i].f, we, o);
            check($sformatf("tbl%0d", i), {18'd0, o[17:9]},
                  {18'd0, tbl[i].eg, tbl[i].ea, tbl[i].ew});
            check($sformatf("tbl%0d_din", i), {24'd0, o[8:1]},
                  {24'd0, tbl[i].ed});
        end

        // All lanes streaming: order 0,1,2,3,0 with one bubble
        do_reset();
        for (int c = 0; c < 25; c++) begin
            apply(4'hF, 4'h0, 1'b0, we, o);
            check($sformatf("rr_order%0d", c), {28'd0, o[17:14]},
                  (c % 5 == 0) ? 32'd0 : 32'(1 << ((c / 5) % 4)));
        end

        // Async reset mid-burst on lane 1, then restart from lane 0
        do_reset();
        apply(4'b0010, 4'h0, 1'b0, we, o);
        apply(4'b0010, 4'h0, 1'b0, we, o);
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_out(), 32'd0);
        mg   = -1;
        mcnt = 0;
        mptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'b0011, 4'h0, 1'b0, we, o);
        apply(4'b0011, 4'h0, 1'b0, we, o);
        check("rst_restart", {28'd0, o[17:14]}, 32'd1);

        // 16-deep FIFO, never drained, all lanes streaming
        do_reset();
        din  = 32'hD4C3B2A1;
        fcnt = 0;
        for (int c = 0; c < 40; c++) begin
            apply(4'hF, 4'h0, fcnt >= 16, we, o);
            if (we) begin
                check("we_while_full", {31'd0, fcnt >= 16}, 32'd0);
                fcnt++;
            end
        end
        check("fifo_words", 32'(fcnt), 32'd16);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            din = $urandom;
            apply(4'($urandom),
                  4'($urandom & $urandom),
                  ($urandom % 4) == 0, we, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule
